// File: rtl/writeback_if.sv
// Writeback bus: retiring-instruction fields in, debug read and status out.
// master = retire source (pipeline or bench), slave = writeback stage.
interface writeback_if;
    logic               commit;
    logic [3:0]         icode;
    logic [3:0]         rA;
    logic [3:0]         rB;
    logic               cnd;
    logic signed [63:0] valE;
    logic signed [63:0] valM;
    logic               mem_error;
    logic [3:0]         dbg_sel;
    logic signed [63:0] dbg_val;
    logic [1:0]         stat;
    logic [31:0]        retired;

    modport master (
        output commit, icode, rA, rB, cnd, valE, valM, mem_error, dbg_sel,
        input  dbg_val, stat, retired
    );

    modport slave (
        input  commit, icode, rA, rB, cnd, valE, valM, mem_error, dbg_sel,
        output dbg_val, stat, retired
    );
endinterface

// File: rtl/writeback.sv
// Y86-64 writeback: register file, machine status and retire counter.
// Ports: clk, reset (async, active-high), wb (writeback_if.slave):
//   commit/icode/rA/rB/cnd/valE/valM/mem_error in, dbg_sel in,
//   dbg_val (comb read, 0 for index 15), stat (AOK/HLT/ADR/INS), retired out.
module writeback #(
    parameter int unsigned RSP_IDX  = 4,
    parameter logic [3:0]  NONE_REG = 4'hF
) (
    input  logic       clk,
    input  logic       reset,
    writeback_if.slave wb
);

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_e;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OP    = 4'h6;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [3:0] RSP = RSP_IDX[3:0];

    localparam logic signed [63:0] RST_VALS [15] = '{
        64'sd5,   64'sd45, -64'sd90, 64'sd54,
        64'sd32,  64'sd21,  64'sd56, 64'sd33,
        -64'sd77, 64'sd0,   64'sd34, 64'sd7,
        64'sd5,  -64'sd9,   64'sd16
    };

    logic signed [63:0] regs_q [15];
    logic signed [63:0] regs_d [15];
    stat_e              stat_q;
    stat_e              stat_d;
    logic [31:0]        retired_q;
    logic [31:0]        retired_d;

    logic [3:0] dst_e;
    logic [3:0] dst_m;
    logic       accept;
    logic       illegal;
    logic       do_write;

    // Destination decode.
    always_comb begin
        dst_e = NONE_REG;
        dst_m = NONE_REG;
        unique case (wb.icode)
            I_CMOV:  dst_e = wb.cnd ? wb.rB : NONE_REG;
            I_IRMOV: dst_e = wb.rB;
            I_OP:    dst_e = wb.rB;
            I_MRMOV: dst_m = wb.rA;
            I_CALL:  dst_e = RSP;
            I_RET:   dst_e = RSP;
            I_PUSH:  dst_e = RSP;
            I_POP: begin
                dst_e = RSP;
                dst_m = wb.rA;
            end
            default: begin
                dst_e = NONE_REG;
                dst_m = NONE_REG;
            end
        endcase
    end

    assign accept   = wb.commit && (stat_q == STAT_AOK);
    assign illegal  = wb.icode > I_POP;
    assign do_write = accept && !wb.mem_error && !illegal
                      && (wb.icode != I_HALT);

    // Next state. Address errors outrank illegal opcodes and halt.
    always_comb begin
        stat_d    = stat_q;
        retired_d = retired_q;
        if (accept) begin
            if (wb.mem_error) begin
                stat_d = STAT_ADR;
            end else if (illegal) begin
                stat_d = STAT_INS;
            end else if (wb.icode == I_HALT) begin
                stat_d = STAT_HLT;
            end else begin
                retired_d = retired_q + 32'd1;
            end
        end
    end

    // Register writes; the M port is applied last so it wins on
    // a shared destination (popq %rsp).
    always_comb begin
        for (int i = 0; i < 15; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (do_write) begin
            for (int i = 0; i < 15; i++) begin
                if (dst_e != NONE_REG && dst_e == i[3:0]) begin
                    regs_d[i] = wb.valE;
                end
                if (dst_m != NONE_REG && dst_m == i[3:0]) begin
                    regs_d[i] = wb.valM;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= RST_VALS[i];
            end
            stat_q    <= STAT_AOK;
            retired_q <= 32'd0;
        end else begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= regs_d[i];
            end
            stat_q    <= stat_d;
            retired_q <= retired_d;
        end
    end

    // Debug read sees only committed state, so a write shows up
    // the cycle after its edge.
    always_comb begin
        wb.dbg_val = 64'sd0;
        if (wb.dbg_sel != 4'hF) begin
            wb.dbg_val = regs_q[wb.dbg_sel];
        end
    end

    assign wb.stat    = stat_q;
    assign wb.retired = retired_q;

endmodule
